// File: rtl/aes_run_sequencer.sv
// aes_run_sequencer
//   Run sequencer for the AES top level. One run is started with a start
//   pulse on a selected key-size channel. The run then presents the
//   plaintext, the encrypt result and the decrypt result in turn on out_data.
//   Each of the encrypt and decrypt steps lasts Nr(ch)+1 cycles.
//   Channel c (1..NCH) uses Nr(c) = NR_BASE + NR_STEP*(c-1).
//
// Ports
//   clk         single clock, rising edge
//   reset       synchronous, active-high
//   sel         channel select, 0 = idle/blank, values above NCH read as 0
//   start       single-cycle run request
//   msg_in      plaintext message
//   enc_in      packed encrypt results, channel c at [(c-1)*DATA_W +: DATA_W]
//   dec_in      packed decrypt results, same packing
//   byte_sel    display byte index, 0 = out_data[7:0]
//   core_reset  restart pulse to the enc/dec cores (also high during reset)
//   out_data    registered output word
//   out_byte    byte byte_sel of out_data (combinational)
//   phase       0 IDLE, 1 LOAD, 2 ENC, 3 DEC/HOLD
//   busy        high in LOAD, ENC, DEC
//   done        high in HOLD
//   match       decrypt self-check result
//
// Build option
//   AES_SEQ_VERIFY_EN  when defined, the final decrypt word is compared with
//                      the message latched in LOAD and the result is shown
//                      on match while in HOLD. When undefined, match is 0.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | blank output, waiting for start with a valid sel
// LOAD   | one cycle: present msg_in, pulse core_reset, arm the timer
// ENC    | present enc_in[ch] for Nr(ch)+1 cycles
// DEC    | present dec_in[ch] for Nr(ch)+1 cycles
// HOLD   | keep tracking dec_in[ch], done high, start re-runs
module aes_run_sequencer #(
  parameter int DATA_W  = 128,
  parameter int NCH     = 3,
  parameter int NR_BASE = 10,
  parameter int NR_STEP = 2,
  localparam int SEL_W  = $clog2(NCH + 1),
  localparam int NBYTES = DATA_W / 8,
  localparam int BSEL_W = (NBYTES > 1) ? $clog2(NBYTES) : 1,
  localparam int NR_MAX = NR_BASE + NR_STEP * (NCH - 1),
  localparam int CNT_W  = $clog2(NR_MAX + 2)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  start,
  input  logic [DATA_W-1:0]     msg_in,
  input  logic [NCH*DATA_W-1:0] enc_in,
  input  logic [NCH*DATA_W-1:0] dec_in,
  input  logic [BSEL_W-1:0]     byte_sel,
  output logic                  core_reset,
  output logic [DATA_W-1:0]     out_data,
  output logic [7:0]            out_byte,
  output logic [1:0]            phase,
  output logic                  busy,
  output logic                  done,
  output logic                  match
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ENC,
    S_DEC,
    S_HOLD
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [SEL_W-1:0]   ch;
  logic [SEL_W-1:0]   sel_v;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [CNT_W-1:0]   nr_ch;
  logic [DATA_W-1:0]  enc_sel;
  logic [DATA_W-1:0]  dec_sel;
  logic [DATA_W-1:0]  data_nxt;
  logic               abort;
  logic               core_reset_q;

  // Out-of-range selects behave exactly like sel = 0.
  always_comb begin
    sel_v = sel;
    if (sel > SEL_W'(NCH)) sel_v = '0;
  end

  // Per-channel round count and data slices for the latched channel.
  always_comb begin
    nr_ch   = '0;
    enc_sel = '0;
    dec_sel = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ch == SEL_W'(c + 1)) begin
        nr_ch   = CNT_W'(NR_BASE + NR_STEP * c);
        enc_sel = enc_in[c*DATA_W +: DATA_W];
        dec_sel = dec_in[c*DATA_W +: DATA_W];
      end
    end
  end

  // Step timer is a down-counter loaded with Nr(ch); each of ENC and DEC
  // ends on the cycle it reads zero, giving Nr(ch)+1 cycles per step.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    abort     = (state != S_IDLE) && (sel_v != ch);
    case (state)
      S_IDLE: begin
        if (start && (sel_v != '0)) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        state_nxt = S_ENC;
        cnt_nxt   = nr_ch;
      end
      S_ENC: begin
        if (cnt == '0) begin
          state_nxt = S_DEC;
          cnt_nxt   = nr_ch;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_DEC: begin
        if (cnt == '0) state_nxt = S_HOLD;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      S_HOLD: begin
        // sel_v == ch here unless aborting, so a start is always valid.
        if (start) state_nxt = S_LOAD;
      end
      default: state_nxt = S_IDLE;
    endcase
    // A channel change wins over everything, including a start.
    if (abort) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end
  end

  // HOLD presents the same word as DEC, following the live decrypt output.
  always_comb begin
    data_nxt = '0;
    case (state_nxt)
      S_LOAD:         data_nxt = msg_in;
      S_ENC:          data_nxt = enc_sel;
      S_DEC, S_HOLD:  data_nxt = dec_sel;
      default:        data_nxt = '0;
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      ch           <= '0;
      cnt          <= '0;
      out_data     <= '0;
      phase        <= 2'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      core_reset_q <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      out_data <= data_nxt;
      if (state_nxt == S_LOAD) ch <= sel_v;
      case (state_nxt)
        S_LOAD:        phase <= 2'd1;
        S_ENC:         phase <= 2'd2;
        S_DEC, S_HOLD: phase <= 2'd3;
        default:       phase <= 2'd0;
      endcase
      busy         <= (state_nxt == S_LOAD) || (state_nxt == S_ENC) ||
                      (state_nxt == S_DEC);
      done         <= (state_nxt == S_HOLD);
      core_reset_q <= (state_nxt == S_LOAD);
    end
  end

  // The cores must also see a restart while reset itself is high.
  assign core_reset = core_reset_q | reset;

  always_comb begin
    out_byte = '0;
    for (int b = 0; b < NBYTES; b++) begin
      if (byte_sel == BSEL_W'(b)) out_byte = out_data[b*8 +: 8];
    end
  end

`ifdef AES_SEQ_VERIFY_EN
  logic [DATA_W-1:0] msg_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      msg_q <= '0;
      match <= 1'b0;
    end else begin
      if (state_nxt == S_LOAD) msg_q <= msg_in;
      if ((state == S_DEC) && (state_nxt == S_HOLD))
        match <= (dec_sel == msg_q);
      else if (state_nxt != S_HOLD)
        match <= 1'b0;
    end
  end
`else
  assign match = 1'b0;
`endif

endmodule

// File: tb/tb_aes_run_sequencer.sv
// Self-checking bench for aes_run_sequencer. Expected behaviour comes from
// the run timeline: offset j after the start edge is LOAD at 0, ENC for
// 1..Nr+1, DEC for Nr+2..2Nr+2 and HOLD from 2Nr+3 on.
module tb_aes_run_sequencer;
  localparam int DATA_W  = 128;
  localparam int NCH     = 3;
  localparam int NR_BASE = 10;
  localparam int NR_STEP = 2;
  localparam int SEL_W   = $clog2(NCH + 1);
  localparam int NBYTES  = DATA_W / 8;
  localparam int BSEL_W  = $clog2(NBYTES);
`ifdef AES_SEQ_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic [SEL_W-1:0]      sel;
  logic                  start;
  logic [DATA_W-1:0]     msg_in;
  logic [NCH*DATA_W-1:0] enc_in;
  logic [NCH*DATA_W-1:0] dec_in;
  logic [BSEL_W-1:0]     byte_sel;
  logic                  core_reset;
  logic [DATA_W-1:0]     out_data;
  logic [7:0]            out_byte;
  logic [1:0]            phase;
  logic                  busy;
  logic                  done;
  logic                  match;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_run_sequencer #(
    .DATA_W (DATA_W),
    .NCH    (NCH),
    .NR_BASE(NR_BASE),
    .NR_STEP(NR_STEP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .start     (start),
    .msg_in    (msg_in),
    .enc_in    (enc_in),
    .dec_in    (dec_in),
    .byte_sel  (byte_sel),
    .core_reset(core_reset),
    .out_data  (out_data),
    .out_byte  (out_byte),
    .phase     (phase),
    .busy      (busy),
    .done      (done),
    .match     (match)
  );

  // ---------------- reference model ----------------
  function automatic int nr_of(input int c);
    return NR_BASE + NR_STEP * (c - 1);
  endfunction

  // 1 LOAD, 2 ENC, 3 DEC, 4 HOLD
  function automatic int region_at(input int j, input int nr);
    if (j == 0)          return 1;
    if (j <= nr + 1)     return 2;
    if (j <= 2 * nr + 2) return 3;
    return 4;
  endfunction

  // {phase, busy, done, core_reset}
  function automatic logic [4:0] exp_status(input int r);
    logic [1:0] ph;
    ph = (r == 4) ? 2'd3 : 2'(r);
    return {ph, (r >= 1 && r <= 3), (r == 4), (r == 1)};
  endfunction

  function automatic logic [DATA_W-1:0] exp_word(input int r, input int c,
                                                 input logic [DATA_W-1:0] m);
    case (r)
      1:       return m;
      2:       return enc_in[(c-1)*DATA_W +: DATA_W];
      3, 4:    return dec_in[(c-1)*DATA_W +: DATA_W];
      default: return '0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] rnd_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_data();
    for (int c = 0; c < NCH; c++) begin
      enc_in[c*DATA_W +: DATA_W] = rnd_word();
      dec_in[c*DATA_W +: DATA_W] = rnd_word();
    end
    byte_sel = BSEL_W'($urandom_range(0, NBYTES - 1));
  endtask

  task automatic go_idle();
    sel   = '0;
    start = 1'b0;
    tick();
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [4:0] st;
    reset = 1'b1;
    sel   = SEL_W'(1);
    start = 1'b1;
    msg_in = rnd_word();
    randomize_data();
    for (int i = 0; i < 3; i++) begin
      tick();
      st = {phase, busy, done, core_reset};
      checks++;
      if (st !== 5'b00001) begin
        errors++;
        $display("FAIL reset_status cyc %0d got %b want 00001", i, st);
      end
      checks++;
      if (out_data !== '0 || match !== 1'b0) begin
        errors++;
        $display("FAIL reset_data cyc %0d got %h/%b want 0/0", i, out_data, match);
      end
    end
    reset = 1'b0;
    start = 1'b0;
    tick();
    st = {phase, busy, done, core_reset};
    checks++;
    if (st !== 5'b00000 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_release got %b/%h want 00000/0", st, out_data);
    end
  endtask

  task automatic test_ch1_run();
    logic [DATA_W-1:0] m;
    logic [DATA_W-1:0] ew;
    logic [4:0] st;
    int r;
    m      = 128'h00112233445566778899aabbccddeeff;
    msg_in = m;
    sel    = SEL_W'(1);
    start  = 1'b1;
    randomize_data();
    for (int j = 0; j <= 25; j++) begin
      tick();
      start = 1'b0;
      r  = region_at(j, nr_of(1));
      ew = exp_word(r, 1, m);
      st = {phase, busy, done, core_reset};
      checks++;
      if (st !== exp_status(r)) begin
        errors++;
        $display("FAIL ch1_status edge %0d got %b want %b", j, st, exp_status(r));
      end
      checks++;
      if (out_data !== ew) begin
        errors++;
        $display("FAIL ch1_data edge %0d got %h want %h", j, out_data, ew);
      end
      checks++;
      if (out_byte !== ew[int'(byte_sel)*8 +: 8]) begin
        errors++;
        $display("FAIL ch1_byte edge %0d sel %0d got %h want %h", j, byte_sel,
                 out_byte, ew[int'(byte_sel)*8 +: 8]);
      end
      if (j == 0) begin
        byte_sel = '0;
        #1;
        checks++;
        if (out_byte !== 8'hff) begin
          errors++;
          $display("FAIL ch1_byte0 got %h want ff", out_byte);
        end
      end
      randomize_data();
    end
    go_idle();
  endtask

  task automatic test_ch3_restart();
    logic [DATA_W-1:0] m;
    logic [4:0] st;
    int r;
    m      = rnd_word();
    msg_in = m;
    sel    = SEL_W'(3);
    start  = 1'b1;
    randomize_data();
    for (int j = 0; j <= 33; j++) begin
      tick();
      start = 1'b0;
      r  = region_at(j, nr_of(3));
      st = {phase, busy, done, core_reset};
      checks++;
      if (st !== exp_status(r) || out_data !== exp_word(r, 3, m)) begin
        errors++;
        $display("FAIL ch3_run edge %0d got %b/%h want %b/%h", j, st, out_data,
                 exp_status(r), exp_word(r, 3, m));
      end
      randomize_data();
    end
    m      = rnd_word();
    msg_in = m;
    start  = 1'b1;
    tick();
    start = 1'b0;
    st = {phase, busy, done, core_reset};
    checks++;
    if (st !== 5'b01101 || out_data !== m) begin
      errors++;
      $display("FAIL ch3_restart got %b/%h want 01101/%h", st, out_data, m);
    end
    randomize_data();
    tick();
    checks++;
    if (phase !== 2'd2 || out_data !== enc_in[2*DATA_W +: DATA_W]) begin
      errors++;
      $display("FAIL ch3_restart_enc got %0d/%h want 2/%h", phase, out_data,
               enc_in[2*DATA_W +: DATA_W]);
    end
    go_idle();
  endtask

  task automatic test_abort();
    logic [4:0] st;
    int c;
    int k;
    int a;
    msg_in = rnd_word();
    sel    = SEL_W'(2);
    start  = 1'b1;
    randomize_data();
    for (int j = 0; j <= 5; j++) begin
      tick();
      start = 1'b0;
      randomize_data();
    end
    checks++;
    if (phase !== 2'd2) begin
      errors++;
      $display("FAIL abort_pre phase got %0d want 2", phase);
    end
    sel   = SEL_W'(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    st = {phase, busy, done, core_reset};
    checks++;
    if (st !== 5'b00000 || out_data !== '0) begin
      errors++;
      $display("FAIL abort_edge6 got %b/%h want 00000/0", st, out_data);
    end
    tick();
    checks++;
    if (phase !== 2'd0 || out_data !== '0) begin
      errors++;
      $display("FAIL abort_no_start got %0d/%h want 0/0", phase, out_data);
    end
    go_idle();
    for (int n = 0; n < 5; n++) begin
      c = $urandom_range(1, NCH);
      k = $urandom_range(0, 2 * nr_of(c) + 5);
      msg_in = rnd_word();
      sel    = SEL_W'(c);
      start  = 1'b1;
      randomize_data();
      for (int j = 0; j <= k; j++) begin
        tick();
        start = 1'b0;
        randomize_data();
      end
      a = $urandom_range(0, 3);
      if (a == c) a = 0;
      sel   = SEL_W'(a);
      start = 1'($urandom_range(0, 1));
      tick();
      start = 1'b0;
      st = {phase, busy, done, core_reset};
      checks++;
      if (st !== 5'b00000 || out_data !== '0 || match !== 1'b0) begin
        errors++;
        $display("FAIL abort_rand ch %0d at %0d to %0d got %b/%h want 00000/0",
                 c, k, a, st, out_data);
      end
      go_idle();
    end
  endtask

  task automatic test_start_while_busy();
    logic [DATA_W-1:0] m;
    logic [4:0] st;
    int r;
    int c;
    int nr;
    for (int n = 0; n < 4; n++) begin
      c  = (n == 0) ? 1 : $urandom_range(1, NCH);
      nr = nr_of(c);
      m      = rnd_word();
      msg_in = m;
      sel    = SEL_W'(c);
      start  = 1'b1;
      randomize_data();
      for (int j = 0; j <= 2 * nr + 4; j++) begin
        tick();
        r  = region_at(j, nr);
        st = {phase, busy, done, core_reset};
        checks++;
        if (st !== exp_status(r) || out_data !== exp_word(r, c, m)) begin
          errors++;
          $display("FAIL busy_start run %0d edge %0d got %b/%h want %b/%h", n, j,
                   st, out_data, exp_status(r), exp_word(r, c, m));
        end
        // next edge e = j+1; a start sampled while busy (e <= 2Nr+3) is ignored
        if (n == 0) start = (j + 1 == 3) || (j + 1 == 20);
        else        start = (j + 1 <= 2 * nr + 3) && ($urandom_range(0, 3) == 0);
        msg_in = rnd_word();
        randomize_data();
      end
      start = 1'b0;
      go_idle();
    end
  endtask

  task automatic test_reset_mid_run();
    logic [4:0] st;
    msg_in = rnd_word();
    sel    = SEL_W'(2);
    start  = 1'b1;
    randomize_data();
    for (int j = 0; j < 8; j++) begin
      tick();
      start = 1'b0;
    end
    reset = 1'b1;
    tick();
    st = {phase, busy, done, core_reset};
    checks++;
    if (st !== 5'b00001 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_mid got %b/%h want 00001/0", st, out_data);
    end
    reset = 1'b0;
    tick();
    st = {phase, busy, done, core_reset};
    checks++;
    if (st !== 5'b00000 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_mid_release got %b/%h want 00000/0", st, out_data);
    end
    go_idle();
  endtask

  task automatic test_verify();
    logic [DATA_W-1:0] m;
    logic em;
    int r;
    for (int it = 0; it < 2; it++) begin
      m      = rnd_word();
      msg_in = m;
      sel    = SEL_W'(1);
      start  = 1'b1;
      randomize_data();
      dec_in[DATA_W-1:0] = (it == 0) ? m : (m ^ (DATA_W'(1) << $urandom_range(0, DATA_W - 1)));
      for (int j = 0; j <= 25; j++) begin
        tick();
        start = 1'b0;
        r  = region_at(j, nr_of(1));
        em = VERIFY && (it == 0) && (r == 4);
        checks++;
        if (match !== em) begin
          errors++;
          $display("FAIL verify_match it %0d edge %0d got %b want %b", it, j, match, em);
        end
        randomize_data();
        dec_in[DATA_W-1:0] = (it == 0) ? m : ~m;
      end
      sel = '0;
      tick();
      checks++;
      if (match !== 1'b0) begin
        errors++;
        $display("FAIL verify_clear it %0d got %b want 0", it, match);
      end
      go_idle();
    end
  endtask

  initial begin
    reset    = 1'b1;
    sel      = '0;
    start    = 1'b0;
    msg_in   = '0;
    enc_in   = '0;
    dec_in   = '0;
    byte_sel = '0;
    test_reset();
    test_ch1_run();
    test_ch3_restart();
    test_abort();
    test_start_while_busy();
    test_reset_mid_run();
    test_verify();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
